// File: rtl/map_dda_tracer_if.sv
// Ray-tracer bundle: ray setup inputs, map ROM address/flag, and hit results.
// master = ray setup / ROM / renderer side, slave = the tracer.
interface map_dda_tracer_if #(
    parameter int MAP_WIDTH_BITS  = 4,
    parameter int MAP_HEIGHT_BITS = 4,
    parameter int DIST_BITS       = 16
);
    logic                       start;
    logic [MAP_WIDTH_BITS-1:0]  start_col;
    logic [MAP_HEIGHT_BITS-1:0] start_row;
    logic                       step_x_neg;
    logic                       step_y_neg;
    logic [DIST_BITS-1:0]       side_dist_x;
    logic [DIST_BITS-1:0]       side_dist_y;
    logic [DIST_BITS-1:0]       delta_x;
    logic [DIST_BITS-1:0]       delta_y;
    logic [MAP_WIDTH_BITS-1:0]  map_col;
    logic [MAP_HEIGHT_BITS-1:0] map_row;
    logic                       map_val;
    logic                       busy;
    logic                       done;
    logic                       timeout;
    logic                       hit_side;
    logic [MAP_WIDTH_BITS-1:0]  hit_col;
    logic [MAP_HEIGHT_BITS-1:0] hit_row;
    logic [DIST_BITS-1:0]       hit_dist;

    modport master (
        output start, start_col, start_row, step_x_neg, step_y_neg,
        output side_dist_x, side_dist_y, delta_x, delta_y, map_val,
        input  map_col, map_row, busy, done, timeout,
        input  hit_side, hit_col, hit_row, hit_dist
    );

    modport slave (
        input  start, start_col, start_row, step_x_neg, step_y_neg,
        input  side_dist_x, side_dist_y, delta_x, delta_y, map_val,
        output map_col, map_row, busy, done, timeout,
        output hit_side, hit_col, hit_row, hit_dist
    );
endinterface

// File: rtl/map_dda_tracer.sv
// DDA grid walker: one cell per clock until the map ROM reports a wall
// or the step limit expires, then reports hit cell, side and distance.
module map_dda_tracer #(
    parameter int MAP_WIDTH_BITS  = 4,
    parameter int MAP_HEIGHT_BITS = 4,
    parameter int DIST_BITS       = 16,
    parameter int MAX_STEPS       = 32
) (
    input logic             clk,
    input logic             reset,
    map_dda_tracer_if.slave bus
);
    localparam int CW = MAP_WIDTH_BITS;
    localparam int RW = MAP_HEIGHT_BITS;
    localparam int DW = DIST_BITS;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACE = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam logic [CW-1:0] COL_ONE = CW'(1);
    localparam logic [RW-1:0] ROW_ONE = RW'(1);
    localparam logic [7:0]    CNT_MAX = 8'(MAX_STEPS);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] col_q, col_d;
    logic [RW-1:0] row_q, row_d;
    logic          xneg_q, xneg_d;
    logic          yneg_q, yneg_d;
    logic [DW-1:0] sdx_q, sdx_d;
    logic [DW-1:0] sdy_q, sdy_d;
    logic [DW-1:0] dx_q, dx_d;
    logic [DW-1:0] dy_q, dy_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          lside_q, lside_d;
    logic [DW-1:0] ldist_q, ldist_d;
    logic          tout_q, tout_d;
    logic          hside_q, hside_d;
    logic [CW-1:0] hcol_q, hcol_d;
    logic [RW-1:0] hrow_q, hrow_d;
    logic [DW-1:0] hdist_q, hdist_d;

    // Side distances clamp at all-ones so a far wall never looks near.
    function automatic logic [DW-1:0] sat_add(
        input logic [DW-1:0] a,
        input logic [DW-1:0] b
    );
        logic [DW:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[DW] ? {DW{1'b1}} : s[DW-1:0];
    endfunction

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        xneg_d  = xneg_q;
        yneg_d  = yneg_q;
        sdx_d   = sdx_q;
        sdy_d   = sdy_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        cnt_d   = cnt_q;
        lside_d = lside_q;
        ldist_d = ldist_q;
        tout_d  = tout_q;
        hside_d = hside_q;
        hcol_d  = hcol_q;
        hrow_d  = hrow_q;
        hdist_d = hdist_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    col_d   = bus.start_col;
                    row_d   = bus.start_row;
                    xneg_d  = bus.step_x_neg;
                    yneg_d  = bus.step_y_neg;
                    sdx_d   = bus.side_dist_x;
                    sdy_d   = bus.side_dist_y;
                    dx_d    = bus.delta_x;
                    dy_d    = bus.delta_y;
                    cnt_d   = 8'd0;
                    state_d = S_TRACE;
                end
            end
            S_TRACE: begin
                if ((cnt_q != 8'd0 && bus.map_val) || cnt_q == CNT_MAX) begin
                    tout_d  = !(cnt_q != 8'd0 && bus.map_val);
                    hside_d = lside_q;
                    hcol_d  = col_q;
                    hrow_d  = row_q;
                    hdist_d = ldist_q;
                    state_d = S_DONE;
                end else begin
                    if (sdx_q < sdy_q) begin
                        col_d   = xneg_q ? col_q - COL_ONE : col_q + COL_ONE;
                        lside_d = 1'b0;
                        ldist_d = sdx_q;
                        sdx_d   = sat_add(sdx_q, dx_q);
                    end else begin
                        row_d   = yneg_q ? row_q - ROW_ONE : row_q + ROW_ONE;
                        lside_d = 1'b1;
                        ldist_d = sdy_q;
                        sdy_d   = sat_add(sdy_q, dy_q);
                    end
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            xneg_q  <= 1'b0;
            yneg_q  <= 1'b0;
            sdx_q   <= '0;
            sdy_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            cnt_q   <= 8'd0;
            lside_q <= 1'b0;
            ldist_q <= '0;
            tout_q  <= 1'b0;
            hside_q <= 1'b0;
            hcol_q  <= '0;
            hrow_q  <= '0;
            hdist_q <= '0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            xneg_q  <= xneg_d;
            yneg_q  <= yneg_d;
            sdx_q   <= sdx_d;
            sdy_q   <= sdy_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            cnt_q   <= cnt_d;
            lside_q <= lside_d;
            ldist_q <= ldist_d;
            tout_q  <= tout_d;
            hside_q <= hside_d;
            hcol_q  <= hcol_d;
            hrow_q  <= hrow_d;
            hdist_q <= hdist_d;
        end
    end

    assign bus.map_col  = col_q;
    assign bus.map_row  = row_q;
    assign bus.busy     = (state_q == S_TRACE) || (state_q == S_DONE);
    assign bus.done     = (state_q == S_DONE);
    assign bus.timeout  = tout_q;
    assign bus.hit_side = hside_q;
    assign bus.hit_col  = hcol_q;
    assign bus.hit_row  = hrow_q;
    assign bus.hit_dist = hdist_q;
endmodule

// File: tb/tb_map_dda_tracer.sv
// Directed bench for map_dda_tracer with a stubbed map ROM whose wall
// pattern is selected per scenario.
module tb_map_dda_tracer;
    logic clk;
    logic reset;
    int   total;
    int   bad;
    int   map_mode;
    int   n;
    logic busy_ok;
    logic seen_done;

    map_dda_tracer_if #(
        .MAP_WIDTH_BITS(4),
        .MAP_HEIGHT_BITS(4),
        .DIST_BITS(16)
    ) bus ();

    map_dda_tracer #(
        .MAP_WIDTH_BITS(4),
        .MAP_HEIGHT_BITS(4),
        .DIST_BITS(16),
        .MAX_STEPS(32)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0: empty, 1: walls at col 8, 2: walls at col 0,
    // 3: walls except (5,5), 4: walls except (5,5) and (6,5)
    always_comb begin
        bus.map_val = 1'b0;
        case (map_mode)
            1: bus.map_val = (bus.map_col == 4'd8);
            2: bus.map_val = (bus.map_col == 4'd0);
            3: bus.map_val = !(bus.map_col == 4'd5 && bus.map_row == 4'd5);
            4: bus.map_val = !((bus.map_col == 4'd5 || bus.map_col == 4'd6)
                               && bus.map_row == 4'd5);
            default: bus.map_val = 1'b0;
        endcase
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ray(input logic [3:0] c, input logic [3:0] r,
                           input logic xn, input logic yn,
                           input logic [15:0] sx, input logic [15:0] sy,
                           input logic [15:0] ddx, input logic [15:0] ddy);
        bus.start_col   = c;
        bus.start_row   = r;
        bus.step_x_neg  = xn;
        bus.step_y_neg  = yn;
        bus.side_dist_x = sx;
        bus.side_dist_y = sy;
        bus.delta_x     = ddx;
        bus.delta_y     = ddy;
    endtask

    // Counts edges after the start-sampling edge until done is seen.
    task automatic wait_done(output int cnt, output logic all_busy);
        cnt = 0;
        all_busy = bus.busy;
        while (!bus.done && cnt < 100) begin
            tick();
            cnt++;
            all_busy = all_busy & bus.busy;
        end
    endtask

    task automatic check_hit(input string tag, input logic [3:0] c,
                             input logic [3:0] r, input logic s,
                             input logic [15:0] d, input logic t);
        chk({tag, "_col"}, 32'(bus.hit_col), 32'(c));
        chk({tag, "_row"}, 32'(bus.hit_row), 32'(r));
        chk({tag, "_side"}, 32'(bus.hit_side), 32'(s));
        chk({tag, "_dist"}, 32'(bus.hit_dist), 32'(d));
        chk({tag, "_tout"}, 32'(bus.timeout), 32'(t));
    endtask

    initial begin
        total = 0;
        bad = 0;
        map_mode = 0;
        reset = 1'b1;
        bus.start = 1'b0;
        set_ray(4'd0, 4'd0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        reset = 1'b0;
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_mcol", 32'(bus.map_col), 32'd0);
        check_hit("rst", 4'd0, 4'd0, 1'b0, 16'h0, 1'b0);

        // Basic X/Y path with a tie resolved to Y
        map_mode = 1;
        set_ray(4'd5, 4'd5, 1'b0, 1'b0, 16'h0100, 16'h0300, 16'h0100, 16'h0400);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(n, busy_ok);
        chk("basic_lat", 32'(n), 32'd5);
        check_hit("basic", 4'd8, 4'd6, 1'b0, 16'h0300, 1'b0);
        tick();
        chk("basic_pulse", 32'(bus.done), 32'd0);

        // Negative X step into the border wall
        map_mode = 2;
        set_ray(4'd1, 4'd3, 1'b1, 1'b0, 16'h0010, 16'hFFFF, 16'h0100, 16'h0100);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(n, busy_ok);
        chk("neg_lat", 32'(n), 32'd2);
        check_hit("neg", 4'd0, 4'd3, 1'b0, 16'h0010, 1'b0);
        tick();

        // Timeout on an empty map; X and Y steps alternate
        map_mode = 0;
        set_ray(4'd5, 4'd5, 1'b0, 1'b0, 16'h0100, 16'h0180, 16'h0100, 16'h0100);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(n, busy_ok);
        chk("tout_lat", 32'(n), 32'd33);
        chk("tout_busy", 32'(busy_ok), 32'd1);
        check_hit("tout", 4'd5, 4'd5, 1'b1, 16'h1080, 1'b1);
        tick();
        chk("tout_idle", 32'(bus.busy), 32'd0);

        // Reset in TRACE cycle 2
        map_mode = 1;
        set_ray(4'd5, 4'd5, 1'b0, 1'b0, 16'h0100, 16'h0300, 16'h0100, 16'h0400);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("mrst_busy", 32'(bus.busy), 32'd0);
        chk("mrst_done", 32'(bus.done), 32'd0);
        chk("mrst_mcol", 32'(bus.map_col), 32'd0);
        chk("mrst_mrow", 32'(bus.map_row), 32'd0);
        check_hit("mrst", 4'd0, 4'd0, 1'b0, 16'h0, 1'b0);
        seen_done = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            seen_done = seen_done | bus.done;
        end
        chk("mrst_nodone", 32'(seen_done), 32'd0);

        // start while busy must not disturb the latched ray
        set_ray(4'd5, 4'd5, 1'b0, 1'b0, 16'h0100, 16'h0300, 16'h0100, 16'h0400);
        bus.start = 1'b1;
        tick();
        set_ray(4'd2, 4'd9, 1'b1, 1'b1, 16'h0001, 16'h0002, 16'h0003, 16'h0004);
        tick();
        tick();
        bus.start = 1'b0;
        n = 0;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        chk("ign_lat", 32'(n), 32'd3);
        check_hit("ign", 4'd8, 4'd6, 1'b0, 16'h0300, 1'b0);
        tick();

        // Saturation: first step X at 0xFFF0
        map_mode = 3;
        set_ray(4'd5, 4'd5, 1'b0, 1'b0, 16'hFFF0, 16'hFFFF, 16'h0100, 16'hFFFF);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(n, busy_ok);
        chk("satA_lat", 32'(n), 32'd2);
        check_hit("satA", 4'd6, 4'd5, 1'b0, 16'hFFF0, 1'b0);
        tick();

        // Saturated sdx ties sdy, so second step must be Y
        map_mode = 4;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done(n, busy_ok);
        chk("satB_lat", 32'(n), 32'd3);
        check_hit("satB", 4'd6, 4'd6, 1'b1, 16'hFFFF, 1'b0);
        tick();

        // Back-to-back with start held: start in DONE is ignored
        map_mode = 1;
        set_ray(4'd5, 4'd5, 1'b0, 1'b0, 16'h0100, 16'h0300, 16'h0100, 16'h0400);
        bus.start = 1'b1;
        tick();
        wait_done(n, busy_ok);
        chk("b2b_lat1", 32'(n), 32'd5);
        tick();
        chk("b2b_idle", 32'(bus.busy), 32'd0);
        n = 1;
        while (!bus.done && n < 100) begin
            tick();
            n++;
        end
        bus.start = 1'b0;
        chk("b2b_period", 32'(n), 32'd7);
        check_hit("b2b", 4'd8, 4'd6, 1'b0, 16'h0300, 1'b0);
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/map_dda_tracer.md
# map_dda_tracer

Grid-stepping ray tracer (DDA) that walks one ray through the map, one cell per clock, until it reaches a wall cell. It sits directly upstream of `map_rom`: it drives the ROM's column/row address, samples its single-bit wall flag, and reports the hit cell, hit side and perpendicular distance to the column renderer. The ray setup stage supplies per-ray start cell, step directions, initial side distances and deltas.

## Interface
- `MAP_WIDTH_BITS`, 4, column address width; must match `map_rom`.
- `MAP_HEIGHT_BITS`, 4, row address width; must match `map_rom`.
- `DIST_BITS`, 16, width of unsigned fixed-point distances.
- `MAX_STEPS`, 32, step limit before timeout; valid range 1..255.

- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: begin a trace; sampled only in IDLE.
- `start_col` in MAP_WIDTH_BITS: ray origin cell column.
- `start_row` in MAP_HEIGHT_BITS: ray origin cell row.
- `step_x_neg` in 1: 1 = column decrements on an X step.
- `step_y_neg` in 1: 1 = row decrements on a Y step.
- `side_dist_x` in DIST_BITS: initial distance to the first X grid line.
- `side_dist_y` in DIST_BITS: initial distance to the first Y grid line.
- `delta_x` in DIST_BITS: distance between successive X grid lines.
- `delta_y` in DIST_BITS: distance between successive Y grid lines.
- `map_col` out MAP_WIDTH_BITS: registered address to `map_rom` `i_col`.
- `map_row` out MAP_HEIGHT_BITS: registered address to `map_rom` `i_row`.
- `map_val` in 1: wall flag from `map_rom` `o_val`, combinational from `map_col`/`map_row`.
- `busy` out 1: high in TRACE and DONE.
- `done` out 1: one-cycle pulse when results are valid.
- `timeout` out 1: qualified by `done`; 1 = step limit reached with no hit.
- `hit_side` out 1: 0 = last step was X (vertical wall face), 1 = Y.
- `hit_col` out MAP_WIDTH_BITS, `hit_row` out MAP_HEIGHT_BITS: hit cell.
- `hit_dist` out DIST_BITS: perpendicular distance to the hit face.

## Operation
- States: IDLE, TRACE, DONE.
- IDLE: if `start`, latch all ray inputs. Load `map_col`/`map_row` with the start cell and the working side distances with the initial values. Clear the step counter. Go to TRACE.
- TRACE, evaluated in priority order each cycle:
  1. If step count ≠ 0 and `map_val` = 1: capture the hit registers and go to DONE with `timeout` = 0. The start cell is never tested.
  2. Else if step count = MAX_STEPS: capture the current cell, side and dist, and go to DONE with `timeout` = 1.
  3. Else take one step:
     - If `sdx < sdy` (strict): column ±1, `last_side` = 0, `last_dist` = sdx, sdx += `delta_x`.
     - Otherwise (ties go to Y): row ±1, `last_side` = 1, `last_dist` = sdy, sdy += `delta_y`.
     - Increment the step count.
- DONE: `done` = 1 for exactly this cycle, then return to IDLE. Hit outputs hold until the next hit/timeout capture.
- Arithmetic:
  - Side distance adds saturate at all-ones; they do not wrap.
  - Column/row arithmetic is modulo 2^width. Map borders normally prevent wrap, and wrap is not an error.
  - The step counter is 8 bits.
- `start` while `busy` is ignored. `start` in the same cycle as DONE is also ignored; it is accepted in the following IDLE cycle.
- Reset, including mid-trace, forces IDLE. All outputs reset to 0: `busy`, `done`, `timeout`, `hit_*`, `map_col`, `map_row`.

## Timing
- `map_col`/`map_row` are registered. `map_val` is sampled in the same cycle, so the `map_rom` path sits inside one cycle.
- `start` sampled on edge k → TRACE from cycle k+1. Step n executes in TRACE cycle n.
- Hit after N steps: detected in TRACE cycle N+1, and `done` is high in cycle k+N+2.
- Timeout: `done` is high in cycle k+MAX_STEPS+2.
- Back-to-back rays: the next `start` is accepted no earlier than the cycle after `done`. The minimum period is N+3 cycles.

## Test plan
- Basic hit with X and Y steps. Stimulus: stub map with walls only at col 8; start (5,5); both steps positive; sdx=0x0100, sdy=0x0300, dx=0x0100, dy=0x0400. Required path: (6,5) → (7,5) → tie, Y step to (7,6) → (8,6). Response: `done` 6 cycles after `start`, `hit_col`=8, `hit_row`=6, `hit_side`=0, `hit_dist`=0x0300, `timeout`=0.
- Negative steps against the real `map_rom` border. Stimulus: start (1,3), `step_x_neg`=1, sdx=0x0010, sdy=0xFFFF. Response: hit at (0,3) after 1 step, `hit_side`=0, `hit_dist`=0x0010, `done` 3 cycles after `start`.
- Timeout. Stimulus: stub map all zero, MAX_STEPS=32. Response: `done` in cycle k+34, `timeout`=1, `busy` high from k+1 through k+34.
- Saturation. Stimulus: sdx=0xFFF0, dx=0x0100, sdy=0xFFFF, dy=0xFFFF; stub walls everywhere except the start cell. Response: first step is X with `hit_dist`=0xFFF0; the internal sdx saturates to 0xFFFF, so no wrap, and no spurious X-first behaviour on later rays.
- Reset mid-trace and ignored start. Pulse `reset` at TRACE cycle 2: `busy`, `done`, `map_col`/`map_row` and all `hit_*` are 0 on the next cycle, and no `done` follows. Also assert `start` during TRACE: the latched ray is unchanged and the result matches the first scenario.
